ofdm_cp_frame_sequencer: RTL

- Sequences the CP-adder output multiplexer. Merges three Avalon-ST sources into one framed stream: preamble (channel 2), cyclic prefix (channel 1) and symbol body (channel 0).
- Emits one preamble packet per frame, followed by SYMS_PER_FRAME symbol packets. Each symbol packet is CP_LEN CP samples followed by FFT_LEN body samples.
- Sits between the CP/body buffers and the DAC-side interface. Owns channel tagging, SOP/EOP generation and per-source backpressure.

---
 rtl/ofdm_cp_frame_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ofdm_cp_frame_sequencer.sv
// Frame sequencer for the CP adder: preamble, then CP + body per symbol,
// merged into one Avalon-ST stream with channel tags and SOP/EOP.
module ofdm_cp_frame_sequencer #(
   parameter int DATA_W         = 22,
   parameter int FFT_LEN        = 64,
   parameter int CP_LEN         = 16,
   parameter int PRE_LEN        = 32,
   parameter int SYMS_PER_FRAME = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] pre_data,
   input  logic              pre_valid,
   output logic              pre_ready,
   input  logic [DATA_W-1:0] cp_data,
   input  logic              cp_valid,
   output logic              cp_ready,
   input  logic [DATA_W-1:0] sym_data,
   input  logic              sym_valid,
   output logic              sym_ready,
   input  logic              sym_startofpacket,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_startofpacket,
   output logic              out_endofpacket,
   output logic [1:0]        out_channel,
   output logic              busy,
   output logic [15:0]       frame_count,
   output logic              align_err
);

   localparam int CW = 13;

   typedef enum logic [1:0] {IDLE, PRE, CP, SYM} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [7:0]        sym_idx;
   logic              load_ok;
   logic              sel_valid;
   logic [DATA_W-1:0] sel_data;
   logic [1:0]        sel_ch;
   logic              sel_sop, sel_eop;
   logic              seg_last, sym_last, first, acc;
   logic              frame_done;

   assign load_ok = !out_valid || out_ready;
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      sel_valid  = 1'b0;
      sel_data   = '0;
      sel_ch     = 2'd0;
      seg_last   = 1'b0;
      pre_ready  = 1'b0;
      cp_ready   = 1'b0;
      sym_ready  = 1'b0;
      first      = (cnt == '0);
      sym_last   = (sym_idx == 8'(SYMS_PER_FRAME - 1));
      unique case (state)
         IDLE: if (enable) state_nxt = PRE;
         PRE: begin
            sel_valid = pre_valid;
            sel_data  = pre_data;
            sel_ch    = 2'd2;
            pre_ready = load_ok;
            seg_last  = (cnt == CW'(PRE_LEN - 1));
         end
         CP: begin
            sel_valid = cp_valid;
            sel_data  = cp_data;
            sel_ch    = 2'd1;
            cp_ready  = load_ok;
            seg_last  = (cnt == CW'(CP_LEN - 1));
         end
         SYM: begin
            sel_valid = sym_valid;
            sel_data  = sym_data;
            sel_ch    = 2'd0;
            sym_ready = load_ok;
            seg_last  = (cnt == CW'(FFT_LEN - 1));
         end
         default: ;
      endcase
      acc        = sel_valid && load_ok;
      sel_sop    = first && (state == PRE || state == CP);
      sel_eop    = seg_last && (state == PRE || state == SYM);
      frame_done = acc && seg_last && sym_last && (state == SYM);
      // Segment switch happens on the last accept so the next source
      // is ready the very next cycle (no boundary bubbles).
      if (acc && seg_last) begin
         unique case (state)
            PRE:     state_nxt = CP;
            CP:      state_nxt = SYM;
            SYM:     state_nxt = !sym_last ? CP : (enable ? PRE : IDLE);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state       <= IDLE;
         cnt         <= '0;
         sym_idx     <= '0;
         frame_count <= '0;
         align_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (acc) cnt <= seg_last ? '0 : cnt + CW'(1);
         if (acc && seg_last && state == SYM)
            sym_idx <= sym_last ? 8'd0 : sym_idx + 8'd1;
         if (frame_done) frame_count <= frame_count + 16'd1;
         if (acc && state == SYM && sym_startofpacket != first)
            align_err <= 1'b1;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_channel       <= 2'd0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
      end else if (acc) begin
         out_valid         <= 1'b1;
         out_data          <= sel_data;
         out_channel       <= sel_ch;
         out_startofpacket <= sel_sop;
         out_endofpacket   <= sel_eop;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
